instruction_fetch_unit: RTL and testbench

Sequencer that sits directly downstream of the 8-entry, 12-bit instruction memory. It holds the program counter and drives the memory's address and external-select inputs. It captures the returned instruction word and splits it into opcode and register fields. It then hands the decoded instruction to the execute stage over a valid/ready handshake, advancing sequentially or to a branch target.

---
 rtl/instruction_fetch_unit.sv | 119 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch sequencer: drives the 8-entry instruction memory, decodes the returned word and
// hands it to execute over valid/ready. Define FETCH_HALT_EN to stop fetching on HALT_OPCODE.
module instruction_fetch_unit #(
    parameter int         ADDR_W      = 3,
    parameter int         DATA_W      = 12,
    parameter logic [2:0] HALT_OPCODE = 3'b111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ext_mode,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_isexternal,
    input  logic [DATA_W-1:0] mem_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [2:0]        opcode,
    output logic [2:0]        rd,
    output logic [2:0]        ra,
    output logic [2:0]        rb,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              busy,
    output logic              halted,
    output logic [7:0]        fetch_count
);

    typedef enum logic [2:0] {IDLE, REQ, RESP, HOLD, HALT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;

    // The PC register feeds the memory directly, so the address is registered by construction.
    assign mem_address = pc;

`ifndef FETCH_HALT_EN
    logic unused_halt_opcode;
    assign unused_halt_opcode = ^HALT_OPCODE;
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            pc             <= '0;
            mem_isexternal <= 1'b0;
            instr_valid    <= 1'b0;
            opcode         <= '0;
            rd             <= '0;
            ra             <= '0;
            rb             <= '0;
            instr_pc       <= '0;
            busy           <= 1'b0;
            fetch_count    <= '0;
`ifdef FETCH_HALT_EN
            halted         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    pc <= '0;
                    if (start) begin
                        state          <= REQ;
                        busy           <= 1'b1;
                        mem_isexternal <= ext_mode;
                    end
                end
                REQ: begin
                    state <= RESP;
                end
                RESP: begin
                    opcode      <= mem_data[11:9];
                    rd          <= mem_data[8:6];
                    ra          <= mem_data[5:3];
                    rb          <= mem_data[2:0];
                    instr_pc    <= pc;
                    instr_valid <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    // instr_valid is always high here, so instr_ready alone marks the handshake.
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (fetch_count != 8'hFF)
                            fetch_count <= fetch_count + 8'd1;
                        pc <= branch_en ? branch_target : pc + ADDR_W'(1);
`ifdef FETCH_HALT_EN
                        if (opcode == HALT_OPCODE) begin
                            state  <= HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else
`endif
                        begin
                            state          <= REQ;
                            mem_isexternal <= ext_mode;
                        end
                    end
                end
`ifdef FETCH_HALT_EN
                HALT: begin
                    if (start) begin
                        pc             <= '0;
                        state          <= REQ;
                        busy           <= 1'b1;
                        halted         <= 1'b0;
                        mem_isexternal <= ext_mode;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: synchronous ROM/switch model, transaction-level reference
// model checked every falling edge, plus directed vectors with hand-computed expectations.
module tb_instruction_fetch_unit;

`ifdef FETCH_HALT_EN
    localparam bit HALT_BUILD = 1'b1;
`else
    localparam bit HALT_BUILD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        ext_mode;
    logic [2:0]  mem_address;
    logic        mem_isexternal;
    logic [11:0] mem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  instr_pc;
    logic        branch_en;
    logic [2:0]  branch_target;
    logic        busy;
    logic        halted;
    logic [7:0]  fetch_count;

    logic [11:0] rom [8];
    logic [11:0] switches;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit #(.ADDR_W(3), .DATA_W(12), .HALT_OPCODE(3'b111)) dut (
        .clk(clk), .rst(rst), .start(start), .ext_mode(ext_mode),
        .mem_address(mem_address), .mem_isexternal(mem_isexternal), .mem_data(mem_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .rd(rd), .ra(ra), .rb(rb), .instr_pc(instr_pc),
        .branch_en(branch_en), .branch_target(branch_target),
        .busy(busy), .halted(halted), .fetch_count(fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: read data valid one cycle after the address.
    always @(posedge clk) mem_data <= mem_isexternal ? switches : rom[mem_address];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a fetch launched on an edge delivers its word three edges later.
    bit          m_live, m_halted, m_ext, exp_valid;
    int          m_wait, m_count;
    logic [2:0]  m_pc, m_fpc;
    logic [11:0] m_word;
    logic [2:0]  seen_pc [$];

    task model_launch();
        m_live = 1'b1;
        m_wait = 3;
        m_fpc  = m_pc;
        m_ext  = ext_mode;
        m_word = ext_mode ? switches : rom[m_pc];
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            m_live = 1'b0; m_halted = 1'b0; m_wait = 0; m_count = 0;
            m_pc = '0; m_fpc = '0;
            chk("rst_valid", instr_valid, 0);
            chk("rst_count", fetch_count, 0);
            chk("rst_busy", busy, 0);
            chk("rst_addr", mem_address, 0);
        end else begin
            if (m_wait > 0) m_wait--;
            exp_valid = m_live && (m_wait == 0);
            chk("valid", instr_valid, exp_valid);
            chk("busy", busy, m_live);
            chk("halted", halted, m_halted);
            chk("fetch_count", fetch_count, m_count);
            if (m_live) begin
                chk("mem_address", mem_address, m_fpc);
                chk("mem_isexternal", mem_isexternal, m_ext);
            end
            if (exp_valid) begin
                chk("instr_pc", instr_pc, m_fpc);
                chk("opcode", opcode, m_word[11:9]);
                chk("rd", rd, m_word[8:6]);
                chk("ra", ra, m_word[5:3]);
                chk("rb", rb, m_word[2:0]);
            end
            if (exp_valid && instr_ready) begin
                seen_pc.push_back(instr_pc);
                if (m_count < 255) m_count++;
                m_pc = branch_en ? branch_target : m_fpc + 3'd1;
                if (HALT_BUILD && m_word[11:9] == 3'b111) begin
                    m_live   = 1'b0;
                    m_halted = 1'b1;
                end else begin
                    model_launch();
                end
            end else if (!m_live && start) begin
                m_pc     = '0;
                m_halted = 1'b0;
                model_launch();
            end
        end
    end

    // Returns the number of rising edges waited until instr_valid is seen high.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!instr_valid && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk("wait_valid_timeout", instr_valid, 1);
    endtask

    task automatic accept(input bit br, input logic [2:0] tgt);
        instr_ready = 1'b1; branch_en = br; branch_target = tgt;
        @(posedge clk); #1;
        instr_ready = 1'b0; branch_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int c;
        int fc_saved;
        logic [2:0] s_op, s_rd, s_ra, s_rb, s_pc;

        // rom[a] = {0,a[1:0]} | a | ~a | a+3
        for (int unsigned a = 0; a < 8; a++) begin
            logic [2:0] av;
            av = 3'(a);
            rom[a] = {1'b0, av[1:0], av, ~av, av + 3'd3};
        end
        rst = 1'b0; start = 1'b0; ext_mode = 1'b0; instr_ready = 1'b1;
        branch_en = 1'b0; branch_target = '0; switches = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_opcode", opcode, 0);
        chk("reset_fields", {rd, ra, rb}, 0);
        chk("reset_instr_pc", instr_pc, 0);
        chk("reset_halted", halted, 0);
        chk("reset_isext", mem_isexternal, 0);
        rst = 1'b1;

        // Sequential fetch with instr_ready held high.
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid(c);
        chk("start_latency", c, 2);   // third edge counting the one that sampled start
        for (int i = 0; i < 100 && seen_pc.size() < 8; i++) begin @(posedge clk); #1; end
        chk("eight_handshakes", seen_pc.size(), 8);
        chk("count_after_eight", fetch_count, 8);
        for (int i = 0; i < 100 && seen_pc.size() < 9; i++) begin @(posedge clk); #1; end
        instr_ready = 1'b0;
        chk("nine_handshakes", seen_pc.size(), 9);
        for (int i = 0; i < 9; i++) chk("seq_pc", seen_pc[i], i % 8);

        // Backpressure with a branch request that must be ignored.
        wait_valid(c);
        chk("bp_pc", instr_pc, 1);
        s_op = opcode; s_rd = rd; s_ra = ra; s_rb = rb; s_pc = instr_pc;
        branch_en = 1'b1; branch_target = 3'd5;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_valid", instr_valid, 1);
            chk("bp_stable", {opcode, rd, ra, rb, instr_pc}, {s_op, s_rd, s_ra, s_rb, s_pc});
        end
        accept(1'b0, 3'd0);
        chk("bp_valid_drop", instr_valid, 0);
        wait_valid(c);
        chk("handshake_latency", c, 2);
        chk("bp_one_handshake", fetch_count, 10);
        chk("branch_ignored_pc", instr_pc, 2);

        // Branch at pc 2 to 6; rom[6] = 010_110_001_001.
        accept(1'b1, 3'd6);
        wait_valid(c);
        chk("branch_pc", instr_pc, 6);
        chk("pc6_opcode", opcode, 2);
        chk("pc6_rb", rb, 1);

        // External mode: switches value replaces ROM word at pc 7.
        ext_mode = 1'b1; switches = 12'h005;
        accept(1'b0, 3'd0);
        chk("ext_isext_req", mem_isexternal, 1);
        wait_valid(c);
        chk("ext_pc", instr_pc, 7);
        chk("ext_fields", {opcode, rd, ra, rb}, 12'h005);
        chk("ext_isext_hold", mem_isexternal, 1);
        ext_mode = 1'b0;
        accept(1'b0, 3'd0);
        wait_valid(c);
        chk("wrap_pc", instr_pc, 0);

        // Branch to 5; rom[5] = 001_101_010_000.
        accept(1'b1, 3'd5);
        wait_valid(c);
        chk("pc5_word", {opcode, rd, ra, rb}, 12'h350);

        // Halt opcode at address 3.
        rom[3] = 12'hE00;
        accept(1'b1, 3'd3);
        wait_valid(c);
        chk("halt_word_opcode", opcode, 7);
        accept(1'b0, 3'd0);
        if (HALT_BUILD) begin
            repeat (10) @(posedge clk);
            #1;
            chk("halt_halted", halted, 1);
            chk("halt_no_valid", instr_valid, 0);
            chk("halt_not_busy", busy, 0);
            fc_saved = fetch_count;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            wait_valid(c);
            chk("restart_pc", instr_pc, 0);
            chk("restart_count_kept", fetch_count, fc_saved);
        end else begin
            wait_valid(c);
            chk("nohalt_next_pc", instr_pc, 4);
            chk("nohalt_halted", halted, 0);
        end
        rom[3] = 12'h6E6;

        // Asynchronous reset while holding an instruction.
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("async_valid", instr_valid, 0);
        chk("async_count", fetch_count, 0);
        chk("async_busy", busy, 0);
        chk("async_addr", mem_address, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid(c);
        chk("post_reset_pc", instr_pc, 0);
        chk("post_reset_count", fetch_count, 0);

        // Saturation: ~266 handshakes at one per three cycles.
        instr_ready = 1'b1;
        repeat (800) @(posedge clk);
        #1;
        chk("count_saturated", fetch_count, 255);
        instr_ready = 1'b0;
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
